// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - shared constants for the MIPS hazard controller
package mips_pkg;

  localparam int NB_DEF       = 5;
  localparam int DEPTH_DEF    = 3;
  localparam int LOAD_LAT_DEF = 1;
  localparam int BR_IDX_DEF   = 1;
  localparam int CNT_W_DEF    = 16;

  // Operand source select: 0 is the register file, k is stage entry k
  localparam int FWD_RF = 0;

  localparam int SB_VALID_W   = 1;
  localparam int SB_WR_EN_W   = 1;
  localparam int SB_IS_LOAD_W = 1;

endpackage

// File: rtl/hazard_match.sv
// rtl/hazard_match.sv - youngest-producer priority encoder for one source operand
module hazard_match #(
  parameter int NB    = 5,
  parameter int DEPTH = 3,
  parameter int IW    = $clog2(DEPTH + 1)
) (
  input  logic [NB-1:0]             operand,
  input  logic                      use_op,
  input  logic [DEPTH-1:0]          sb_valid,
  input  logic [DEPTH-1:0]          sb_wr_en,
  input  logic [DEPTH-1:0]          sb_is_load,
  input  logic [DEPTH-1:0][NB-1:0]  sb_wr_reg,
  output logic                      hit,
  output logic [IW-1:0]             idx,
  output logic                      is_load
);

  // Scan oldest to youngest so the youngest matching entry is the last writer
  always_comb begin
    hit     = 1'b0;
    idx     = '0;
    is_load = 1'b0;
    for (int k = DEPTH - 1; k >= 0; k--) begin
      if (use_op && (operand != '0) && sb_valid[k] && sb_wr_en[k] &&
          (sb_wr_reg[k] == operand)) begin
        hit     = 1'b1;
        idx     = IW'(k);
        is_load = sb_is_load[k];
      end
    end
  end

endmodule

// File: rtl/mips_hazard_ctrl.sv
// rtl/mips_hazard_ctrl.sv - load-use stall, branch/jump flush and forwarding select
module mips_hazard_ctrl
  import mips_pkg::*;
#(
  parameter int NB       = NB_DEF,
  parameter int DEPTH    = DEPTH_DEF,
  parameter int LOAD_LAT = LOAD_LAT_DEF,
  parameter int BR_IDX   = BR_IDX_DEF,
  parameter int CNT_W    = CNT_W_DEF,
  parameter int FW       = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              id_valid,
  input  logic [NB-1:0]     id_rs,
  input  logic [NB-1:0]     id_rt,
  input  logic              id_use_rs,
  input  logic              id_use_rt,
  input  logic              id_wr_en,
  input  logic [NB-1:0]     id_wr_reg,
  input  logic              id_is_load,
  input  logic              id_jump,
  input  logic              br_taken,
  output logic              stall,
  output logic              flush_if,
  output logic [DEPTH-1:0]  flush_vec,
  output logic [FW-1:0]     fwd_a,
  output logic [FW-1:0]     fwd_b,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  flush_cnt
);

  logic [DEPTH-1:0]         sb_valid;
  logic [DEPTH-1:0]         sb_wr_en;
  logic [DEPTH-1:0]         sb_is_load;
  logic [DEPTH-1:0][NB-1:0] sb_wr_reg;

  logic          hit_a, hit_b, ld_a, ld_b, haz_a, haz_b, issue;
  logic [FW-1:0] idx_a, idx_b;

  hazard_match #(.NB(NB), .DEPTH(DEPTH), .IW(FW)) u_match_a (
    .operand   (id_rs),
    .use_op    (id_use_rs),
    .sb_valid  (sb_valid),
    .sb_wr_en  (sb_wr_en),
    .sb_is_load(sb_is_load),
    .sb_wr_reg (sb_wr_reg),
    .hit       (hit_a),
    .idx       (idx_a),
    .is_load   (ld_a)
  );

  hazard_match #(.NB(NB), .DEPTH(DEPTH), .IW(FW)) u_match_b (
    .operand   (id_rt),
    .use_op    (id_use_rt),
    .sb_valid  (sb_valid),
    .sb_wr_en  (sb_wr_en),
    .sb_is_load(sb_is_load),
    .sb_wr_reg (sb_wr_reg),
    .hit       (hit_b),
    .idx       (idx_b),
    .is_load   (ld_b)
  );

  // A match one stage past the last tracked entry has already written back
  function automatic logic [FW-1:0] next_fwd(input logic h, input logic [FW-1:0] i);
    if (!h || (int'(i) + 1 == DEPTH)) return FW'(FWD_RF);
    return i + FW'(1);
  endfunction

  // Resolving branch is older than anything in ID, so it overrides stall and jump
  always_comb begin
    haz_a    = hit_a && ld_a && (int'(idx_a) < LOAD_LAT);
    haz_b    = hit_b && ld_b && (int'(idx_b) < LOAD_LAT);
    stall    = id_valid && !br_taken && (haz_a || haz_b);
    issue    = id_valid && !stall && !br_taken;
    flush_if = br_taken || (id_jump && !stall);
    for (int k = 0; k < DEPTH; k++) begin
      flush_vec[k] = br_taken && (k < BR_IDX);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sb_valid   <= '0;
      sb_wr_en   <= '0;
      sb_is_load <= '0;
      sb_wr_reg  <= '0;
      fwd_a      <= FW'(FWD_RF);
      fwd_b      <= FW'(FWD_RF);
      stall_cnt  <= '0;
      flush_cnt  <= '0;
    end else begin
      sb_valid[0]   <= issue;
      sb_wr_en[0]   <= id_wr_en;
      sb_is_load[0] <= id_is_load;
      sb_wr_reg[0]  <= id_wr_reg;
      for (int k = 1; k < DEPTH; k++) begin
        sb_valid[k]   <= sb_valid[k-1] && !flush_vec[k-1];
        sb_wr_en[k]   <= sb_wr_en[k-1];
        sb_is_load[k] <= sb_is_load[k-1];
        sb_wr_reg[k]  <= sb_wr_reg[k-1];
      end
      fwd_a <= issue ? next_fwd(hit_a, idx_a) : FW'(FWD_RF);
      fwd_b <= issue ? next_fwd(hit_b, idx_b) : FW'(FWD_RF);
      if (stall && (stall_cnt != '1)) stall_cnt <= stall_cnt + CNT_W'(1);
      if (flush_if && (flush_cnt != '1)) flush_cnt <= flush_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_mips_hazard_ctrl.sv
// tb/tb_mips_hazard_ctrl.sv - randomized and directed checks against a pipeline-slot model
module tb_mips_hazard_ctrl;

  localparam int NB = 5, DEPTH = 3, LOAD_LAT = 1, BR_IDX = 1;

  logic       clk = 1'b0;
  logic       reset;
  logic       id_valid, id_use_rs, id_use_rt, id_wr_en, id_is_load, id_jump, br_taken;
  logic [4:0] id_rs, id_rt, id_wr_reg;
  logic       stall, flush_if, stall_s, flush_if_s;
  logic [2:0] flush_vec, flush_vec_s;
  logic [1:0] fwd_a, fwd_b, fwd_a_s, fwd_b_s;
  logic [15:0] stall_cnt, flush_cnt;
  logic [3:0]  stall_cnt_s, flush_cnt_s;

  always #5 clk = ~clk;

  mips_hazard_ctrl dut (
    .clk(clk), .reset(reset), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
    .id_use_rs(id_use_rs), .id_use_rt(id_use_rt), .id_wr_en(id_wr_en),
    .id_wr_reg(id_wr_reg), .id_is_load(id_is_load), .id_jump(id_jump),
    .br_taken(br_taken), .stall(stall), .flush_if(flush_if), .flush_vec(flush_vec),
    .fwd_a(fwd_a), .fwd_b(fwd_b), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  mips_hazard_ctrl #(.CNT_W(4)) dut_small (
    .clk(clk), .reset(reset), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
    .id_use_rs(id_use_rs), .id_use_rt(id_use_rt), .id_wr_en(id_wr_en),
    .id_wr_reg(id_wr_reg), .id_is_load(id_is_load), .id_jump(id_jump),
    .br_taken(br_taken), .stall(stall_s), .flush_if(flush_if_s), .flush_vec(flush_vec_s),
    .fwd_a(fwd_a_s), .fwd_b(fwd_b_s), .stall_cnt(stall_cnt_s), .flush_cnt(flush_cnt_s)
  );

  typedef struct { bit v; bit we; bit ld; int r; } ent_t;
  ent_t pipe[DEPTH];
  int   m_fwd_a, m_fwd_b, n_stall, n_flush;
  int   n_checks = 0, n_fail = 0;
  int   smp_stall, smp_flush_if, smp_flush_vec, smp_fwd_a, smp_fwd_b, smp_stall_cnt, smp_flush_cnt;

  task automatic check_eq(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int sat(input int n, input int max);
    return (n > max) ? max : n;
  endfunction

  function automatic int youngest(input int op, input bit use_op);
    if (!use_op || op == 0) return -1;
    for (int k = 0; k < DEPTH; k++)
      if (pipe[k].v && pipe[k].we && pipe[k].r == op) return k;
    return -1;
  endfunction

  function automatic int fsel(input int k);
    if (k < 0 || k + 1 == DEPTH) return 0;
    return k + 1;
  endfunction

  task automatic model_clear();
    for (int k = 0; k < DEPTH; k++) pipe[k] = '{0, 0, 0, 0};
    m_fwd_a = 0; m_fwd_b = 0; n_stall = 0; n_flush = 0;
  endtask

  task automatic set_in(input bit v, input int rs, input bit urs, input int rt, input bit urt,
                        input bit we, input int wr, input bit ld, input bit jmp, input bit br);
    id_valid = v; id_rs = 5'(rs); id_use_rs = urs; id_rt = 5'(rt); id_use_rt = urt;
    id_wr_en = we; id_wr_reg = 5'(wr); id_is_load = ld; id_jump = jmp; br_taken = br;
  endtask

  task automatic idle();
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  // Called just after a rising edge; checks the cycle and advances the model
  task automatic do_cycle();
    int ka, kb, e_fv;
    bit haz, e_stall, e_issue, e_fif;
    ka = youngest(int'(id_rs), id_use_rs);
    kb = youngest(int'(id_rt), id_use_rt);
    haz = (ka >= 0 && pipe[ka].ld && ka < LOAD_LAT) || (kb >= 0 && pipe[kb].ld && kb < LOAD_LAT);
    e_stall = id_valid && !br_taken && haz;
    e_issue = id_valid && !e_stall && !br_taken;
    e_fif   = br_taken || (id_jump && !e_stall);
    e_fv    = br_taken ? (1 << BR_IDX) - 1 : 0;
    @(negedge clk);
    smp_stall = int'(stall); smp_flush_if = int'(flush_if); smp_flush_vec = int'(flush_vec);
    smp_fwd_a = int'(fwd_a); smp_fwd_b = int'(fwd_b);
    smp_stall_cnt = int'(stall_cnt); smp_flush_cnt = int'(flush_cnt);
    check_eq("stall", smp_stall, int'(e_stall));
    check_eq("flush_if", smp_flush_if, int'(e_fif));
    check_eq("flush_vec", smp_flush_vec, e_fv);
    check_eq("fwd_a", smp_fwd_a, m_fwd_a);
    check_eq("fwd_b", smp_fwd_b, m_fwd_b);
    check_eq("stall_cnt", smp_stall_cnt, sat(n_stall, 65535));
    check_eq("flush_cnt", smp_flush_cnt, sat(n_flush, 65535));
    check_eq("stall_cnt_w4", int'(stall_cnt_s), sat(n_stall, 15));
    check_eq("flush_cnt_w4", int'(flush_cnt_s), sat(n_flush, 15));
    for (int k = DEPTH - 1; k >= 1; k--) begin
      pipe[k] = pipe[k-1];
      if (br_taken && (k - 1) < BR_IDX) pipe[k].v = 0;
    end
    pipe[0] = '{e_issue, id_wr_en, id_is_load, int'(id_wr_reg)};
    m_fwd_a = e_issue ? fsel(ka) : 0;
    m_fwd_b = e_issue ? fsel(kb) : 0;
    if (e_stall) n_stall++;
    if (e_fif) n_flush++;
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    idle();
    reset = 1'b0;
    model_clear();
    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_stall", int'(stall), 0);
    check_eq("rst_flush_vec", int'(flush_vec), 0);
    check_eq("rst_fwd_a", int'(fwd_a), 0);
    check_eq("rst_stall_cnt", int'(stall_cnt), 0);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk); #1;
  endtask

  initial begin
    idle();
    reset = 1'b1;
    #3;
    do_reset();

    // Load-use: one stall cycle, consumer forwards from entry 2
    set_in(1, 0, 0, 0, 0, 1, 8, 1, 0, 0); do_cycle();
    set_in(1, 8, 1, 0, 0, 0, 0, 0, 0, 0); do_cycle();
    check_eq("lu_stall", smp_stall, 1);
    do_cycle();
    check_eq("lu_issue", smp_stall, 0);
    check_eq("lu_stall_cnt", smp_stall_cnt, 1);
    idle(); do_cycle();
    check_eq("lu_fwd_a", smp_fwd_a, 2);

    // ALU producer forwarded from distances 1, 2 and then register file
    repeat (3) do_cycle();
    set_in(1, 0, 0, 0, 0, 1, 9, 0, 0, 0); do_cycle();
    set_in(1, 0, 0, 9, 1, 0, 0, 0, 0, 0); do_cycle();
    check_eq("alu_nostall", smp_stall, 0);
    do_cycle();
    check_eq("alu_fwd_b_1", smp_fwd_b, 1);
    do_cycle();
    check_eq("alu_fwd_b_2", smp_fwd_b, 2);
    idle(); do_cycle();
    check_eq("alu_fwd_b_0", smp_fwd_b, 0);

    // Register 0 never creates a hazard
    set_in(1, 0, 0, 0, 0, 1, 0, 1, 0, 0); do_cycle();
    set_in(1, 0, 1, 0, 0, 0, 0, 0, 0, 0); do_cycle();
    check_eq("r0_nostall", smp_stall, 0);
    idle(); do_cycle();
    check_eq("r0_fwd_a", smp_fwd_a, 0);

    // Taken branch beats pending load-use stall and a jump
    do_reset();
    set_in(1, 0, 0, 0, 0, 1, 5, 1, 0, 0); do_cycle();
    set_in(1, 5, 1, 0, 0, 1, 6, 1, 1, 1); do_cycle();
    check_eq("br_stall", smp_stall, 0);
    check_eq("br_flush_if", smp_flush_if, 1);
    check_eq("br_flush_vec", smp_flush_vec, 1);
    set_in(1, 6, 1, 0, 0, 0, 0, 0, 0, 0); do_cycle();
    check_eq("br_bubble", smp_stall, 0);
    check_eq("br_flush_cnt", smp_flush_cnt, 1);

    // Randomized traffic over a small register set to provoke hazards
    for (int i = 0; i < 3000; i++) begin
      set_in(($urandom_range(0, 3) != 0), $urandom_range(0, 3), $urandom_range(0, 1),
             $urandom_range(0, 3), $urandom_range(0, 1), $urandom_range(0, 1),
             $urandom_range(0, 3), ($urandom_range(0, 2) == 0), ($urandom_range(0, 7) == 0),
             ($urandom_range(0, 7) == 0));
      do_cycle();
    end

    // Asynchronous reset in the middle of a stall
    idle(); repeat (3) do_cycle();
    set_in(1, 0, 0, 0, 0, 1, 7, 1, 0, 0); do_cycle();
    set_in(1, 7, 1, 0, 0, 0, 0, 0, 0, 0);
    #2;
    check_eq("pre_rst_stall", int'(stall), 1);
    reset = 1'b0;
    #1;
    check_eq("mid_rst_stall", int'(stall), 0);
    check_eq("mid_rst_fwd_a", int'(fwd_a), 0);
    check_eq("mid_rst_fwd_b", int'(fwd_b), 0);
    check_eq("mid_rst_stall_cnt", int'(stall_cnt), 0);
    check_eq("mid_rst_flush_cnt", int'(flush_cnt), 0);
    check_eq("mid_rst_cnt_w4", int'(stall_cnt_s), 0);
    model_clear();
    @(negedge clk);
    reset = 1'b1;
    idle();
    @(posedge clk); #1;
    set_in(1, 0, 0, 0, 0, 1, 4, 1, 0, 0); do_cycle();
    set_in(1, 0, 0, 4, 1, 0, 0, 0, 0, 0); do_cycle();
    check_eq("post_rst_stall", smp_stall, 1);
    do_cycle();
    idle(); do_cycle();
    check_eq("post_rst_fwd_b", smp_fwd_b, 2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
